// File: rtl/id_issue_queue.sv
// -----------------------------------------------------------------------------
// id_issue_queue
//   Decode/issue buffer between the IF stage and the ID/EX boundary. Fetched
//   instructions are held in a DEPTH-entry FIFO. The head instruction is
//   pre-decoded for its source and destination GPRs. A per-register load
//   scoreboard holds the head while one of its sources waits on a load that
//   is still in flight.
//
//   Ports
//     clk           : clock, all state updates on the rising edge
//     rst           : synchronous reset, active-low
//     flush         : empties the FIFO (scoreboard is kept)
//     in_valid/in_ready, in_addr, in_inst, in_delayslot : push side from IF
//     out_valid/out_ready, out_addr, out_inst, out_delayslot : head to ID/EX
//     out_rs_en, out_rt_en      : head reads rs / rt
//     out_wr_en, out_wr_addr    : head writes a GPR (never r0) and which one
//     out_is_load               : head is a load
//     stall_hazard              : head present but blocked by the scoreboard
//     count                     : number of occupied entries
// -----------------------------------------------------------------------------
module id_issue_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int LOAD_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [INST_WIDTH-1:0]   in_inst,
    input  logic                    in_delayslot,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [INST_WIDTH-1:0]   out_inst,
    output logic                    out_delayslot,
    output logic                    out_rs_en,
    output logic                    out_rt_en,
    output logic                    out_wr_en,
    output logic [4:0]              out_wr_addr,
    output logic                    out_is_load,
    output logic                    stall_hazard,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
    logic                  ds_mem_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       sb_q [32];
    logic [2:0]       sb_d [32];

    logic [INST_WIDTH-1:0] head_inst_s;
    logic [5:0] op_s, funct_s;
    logic [4:0] rs_s, rt_s, rd_s, wa_s;
    logic       rs_en_s, rt_en_s, wr_s, wr_en_s, is_load_s;
    logic       head_valid_s, hazard_s, push_s, pop_s, sb_set_s;

    assign head_inst_s = inst_mem_q[rd_ptr_q];
    assign op_s        = head_inst_s[31:26];
    assign rs_s        = head_inst_s[25:21];
    assign rt_s        = head_inst_s[20:16];
    assign rd_s        = head_inst_s[15:11];
    assign funct_s     = head_inst_s[5:0];

    // Pre-decode of the head instruction: which GPRs it reads and writes.
    always_comb begin
        rs_en_s   = 1'b0;
        rt_en_s   = 1'b0;
        wr_s      = 1'b0;
        wa_s      = 5'd0;
        is_load_s = 1'b0;
        casez (op_s)
            6'b000000: begin
                rs_en_s = 1'b1;
                rt_en_s = 1'b1;
                wr_s    = (funct_s != 6'h08);   // JR writes nothing
                wa_s    = rd_s;
            end
            6'b100???: begin
                rs_en_s   = 1'b1;
                wr_s      = 1'b1;
                wa_s      = rt_s;
                is_load_s = 1'b1;
            end
            6'b101???: begin
                rs_en_s = 1'b1;
                rt_en_s = 1'b1;
            end
            6'b001???: begin
                rs_en_s = (op_s != 6'h0F);      // LUI has no register source
                wr_s    = 1'b1;
                wa_s    = rt_s;
            end
            6'b00010?: begin
                rs_en_s = 1'b1;
                rt_en_s = 1'b1;
            end
            6'b00011?: begin
                rs_en_s = 1'b1;
            end
            6'b000001: begin
                rs_en_s = 1'b1;
                wr_s    = rt_s[4];              // the and-link REGIMM forms
                wa_s    = 5'd31;
            end
            6'b000011: begin
                wr_s = 1'b1;
                wa_s = 5'd31;
            end
            6'b010000: begin
                if (rs_s == 5'd0) begin
                    wr_s = 1'b1;
                    wa_s = rt_s;
                end else if (rs_s == 5'd4) begin
                    rt_en_s = 1'b1;
                end else begin
                    wr_s = 1'b0;
                end
            end
            default: begin
                wr_s = 1'b0;
            end
        endcase
    end

    assign wr_en_s      = wr_s && (wa_s != 5'd0);
    assign head_valid_s = (count_q != CNT_W'(0));
    assign hazard_s     = head_valid_s &&
                          ((rs_en_s && (sb_q[rs_s] != 3'd0)) ||
                           (rt_en_s && (sb_q[rt_s] != 3'd0)));
    assign in_ready     = (count_q != CNT_W'(DEPTH));
    assign push_s       = in_valid && in_ready;
    assign pop_s        = out_valid && out_ready;
    assign sb_set_s     = pop_s && !flush && is_load_s && wr_en_s;

    // Pointer and occupancy next state; flush discards both push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Scoreboard next state: count down every cycle, reload on load issue.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            if (sb_set_s && (wa_s == 5'(i))) begin
                sb_d[i] = 3'(LOAD_LAT);
            end else if (sb_q[i] != 3'd0) begin
                sb_d[i] = sb_q[i] - 3'd1;
            end else begin
                sb_d[i] = 3'd0;
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < 32; i++) begin
                sb_q[i] <= 3'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < 32; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    // FIFO payload storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            addr_mem_q[wr_ptr_q] <= in_addr;
            inst_mem_q[wr_ptr_q] <= in_inst;
            ds_mem_q[wr_ptr_q]   <= in_delayslot;
        end
    end

    assign out_valid     = head_valid_s && !hazard_s;
    assign stall_hazard  = hazard_s;
    assign out_addr      = addr_mem_q[rd_ptr_q];
    assign out_inst      = head_inst_s;
    assign out_delayslot = ds_mem_q[rd_ptr_q];
    assign out_rs_en     = rs_en_s;
    assign out_rt_en     = rt_en_s;
    assign out_wr_en     = wr_en_s;
    assign out_wr_addr   = wa_s;
    assign out_is_load   = is_load_s;
    assign count         = count_q;

endmodule

// File: tb/tb_id_issue_queue.sv
module tb_id_issue_queue;

    localparam int DEPTH    = 4;
    localparam int LOAD_LAT = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_inst;
    logic        in_delayslot;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_inst;
    logic        out_delayslot;
    logic        out_rs_en;
    logic        out_rt_en;
    logic        out_wr_en;
    logic [4:0]  out_wr_addr;
    logic        out_is_load;
    logic        stall_hazard;
    logic [2:0]  count;

    id_issue_queue #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .DEPTH      (DEPTH),
        .LOAD_LAT   (LOAD_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_inst       (in_inst),
        .in_delayslot  (in_delayslot),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_inst      (out_inst),
        .out_delayslot (out_delayslot),
        .out_rs_en     (out_rs_en),
        .out_rt_en     (out_rt_en),
        .out_wr_en     (out_wr_en),
        .out_wr_addr   (out_wr_addr),
        .out_is_load   (out_is_load),
        .stall_hazard  (stall_hazard),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    logic [31:0] addr_ctr = 32'h0000_1000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        ds;
    } ent_t;

    typedef struct {
        bit rs_en;
        bit rt_en;
        bit wr_en;
        bit is_load;
        int wa;
    } dec_t;

    ent_t q[$];
    int   sb[32];

    function automatic dec_t model_decode(logic [31:0] i);
        dec_t d;
        int op = int'(i[31:26]);
        int rs = int'(i[25:21]);
        int rt = int'(i[20:16]);
        int rd = int'(i[15:11]);
        int fn = int'(i[5:0]);
        int w  = -1;
        d = '{default: 0};
        if (op == 0) begin
            d.rs_en = 1; d.rt_en = 1;
            if (fn != 8) w = rd;
        end else if (op >= 32 && op < 40) begin
            d.rs_en = 1; d.is_load = 1; w = rt;
        end else if (op >= 40 && op < 48) begin
            d.rs_en = 1; d.rt_en = 1;
        end else if (op >= 8 && op < 16) begin
            d.rs_en = (op != 15); w = rt;
        end else if (op == 4 || op == 5) begin
            d.rs_en = 1; d.rt_en = 1;
        end else if (op == 6 || op == 7) begin
            d.rs_en = 1;
        end else if (op == 1) begin
            d.rs_en = 1;
            if (rt >= 16) w = 31;
        end else if (op == 3) begin
            w = 31;
        end else if (op == 16) begin
            if (rs == 0) w = rt;
            else if (rs == 4) d.rt_en = 1;
        end
        d.wr_en = (w > 0);
        d.wa    = (w > 0) ? w : 0;
        return d;
    endfunction

    function automatic bit m_haz();
        dec_t d;
        if (q.size() == 0) return 1'b0;
        d = model_decode(q[0].inst);
        return (d.rs_en && sb[q[0].inst[25:21]] > 0) ||
               (d.rt_en && sb[q[0].inst[20:16]] > 0);
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        bit   push, pop;
        dec_t d;
        if (!rst) begin
            q.delete();
            foreach (sb[i]) sb[i] = 0;
        end else begin
            push = in_valid && (q.size() < DEPTH);
            pop  = (q.size() != 0) && !m_haz() && out_ready;
            if (q.size() != 0) d = model_decode(q[0].inst);
            else d = '{default: 0};
            foreach (sb[i]) if (sb[i] > 0) sb[i]--;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) begin
                    if (d.is_load && d.wr_en) sb[d.wa] = LOAD_LAT;
                    void'(q.pop_front());
                end
                if (push) q.push_back('{in_addr, in_inst, in_delayslot});
            end
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        dec_t d;
        bit   haz;
        if (chk_en) begin
            haz = m_haz();
            chk("count", count, q.size());
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("out_valid", out_valid, (q.size() != 0) && !haz);
            chk("stall_hazard", stall_hazard, haz);
            if (q.size() != 0) begin
                d = model_decode(q[0].inst);
                chk("out_addr", out_addr, q[0].addr);
                chk("out_inst", out_inst, q[0].inst);
                chk("out_delayslot", out_delayslot, q[0].ds);
                chk("out_rs_en", out_rs_en, d.rs_en);
                chk("out_rt_en", out_rt_en, d.rt_en);
                chk("out_wr_en", out_wr_en, d.wr_en);
                chk("out_is_load", out_is_load, d.is_load);
                if (d.wr_en) chk("out_wr_addr", out_wr_addr, d.wa);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jinst(int k);
        return {6'h02, 26'(k)};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        case ($urandom_range(0, 11))
            0:       op = 6'h00;
            1:       op = 6'h23;
            2:       op = 6'h20;
            3:       op = 6'h2B;
            4:       op = 6'h08;
            5:       op = 6'h0F;
            6:       op = 6'h04;
            7:       op = 6'h06;
            8:       op = 6'h01;
            9:       op = 6'h03;
            10:      op = 6'h10;
            default: op = 6'($urandom_range(0, 63));
        endcase
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        if (op == 6'h10) rs = ($urandom_range(0, 1) != 0) ? 5'd4 : 5'd0;
        if (op == 6'h01) rt[4] = 1'($urandom_range(0, 1));
        fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
        return {op, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
    endfunction

    task automatic cyc(input bit v, input logic [31:0] inst, input bit rdy,
                       input bit fl, input bit rstn);
        in_valid     = v;
        in_inst      = inst;
        in_addr      = addr_ctr;
        in_delayslot = 1'($urandom_range(0, 1));
        out_ready    = rdy;
        flush        = fl;
        rst          = rstn;
        addr_ctr     = addr_ctr + 32'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_addr = '0; in_inst = '0; in_delayslot = 1'b0;
        cyc(0, jinst(0), 0, 0, 0);
        cyc(0, jinst(0), 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_hazard, 0);

        // Fill: five offers, nothing drained.
        for (int k = 0; k < 5; k++) cyc(1, jinst(k), 0, 0, 1);
        chk("fill_count", count, 4);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_head", out_inst, {6'h02, 26'd0});
        for (int k = 0; k < 4; k++) cyc(0, jinst(0), 1, 0, 1);
        chk("drain_count", count, 0);

        // Load-use: LW r8,0(r1) then ADD r9,r8,r1.
        cyc(1, itype(6'h23, 5'd1, 5'd8, 16'h0010), 0, 0, 1);
        chk("lw_is_load", out_is_load, 1);
        chk("lw_wr_addr", out_wr_addr, 8);
        cyc(1, rtype(5'd8, 5'd1, 5'd9, 6'h20), 1, 0, 1);
        chk("lu_stall_t1", stall_hazard, 1);
        chk("lu_valid_t1", out_valid, 0);
        cyc(0, jinst(0), 1, 0, 1);
        chk("lu_stall_t2", stall_hazard, 1);
        cyc(0, jinst(0), 1, 0, 1);
        chk("lu_valid_t3", out_valid, 1);
        chk("lu_stall_t3", stall_hazard, 0);
        cyc(0, jinst(0), 1, 0, 1);
        chk("lu_drained", count, 0);

        // Load into r0 never creates a dependency.
        cyc(1, itype(6'h23, 5'd1, 5'd0, 16'h0000), 0, 0, 1);
        chk("lw_r0_wr_en", out_wr_en, 0);
        cyc(1, rtype(5'd0, 5'd0, 5'd2, 6'h20), 1, 0, 1);
        chk("r0_no_stall", stall_hazard, 0);
        chk("r0_valid", out_valid, 1);
        cyc(0, jinst(0), 1, 0, 1);

        // Flush with a simultaneous push.
        for (int k = 1; k <= 3; k++) cyc(1, jinst(k), 0, 0, 1);
        chk("pre_flush_count", count, 3);
        cyc(1, jinst(4), 0, 1, 1);
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);

        // Wrap: simultaneous push and pop for 2*DEPTH+1 cycles.
        cyc(1, jinst(100), 0, 0, 1);
        for (int k = 1; k <= 2 * DEPTH + 1; k++) begin
            cyc(1, jinst(100 + k), 1, 0, 1);
            chk("wrap_count", count, 1);
            chk("wrap_head", out_inst, jinst(100 + k));
        end
        cyc(0, jinst(0), 1, 0, 1);

        // Reset while the head is stalled on a load.
        cyc(1, itype(6'h23, 5'd1, 5'd8, 16'h0000), 0, 0, 1);
        cyc(1, rtype(5'd8, 5'd1, 5'd9, 6'h20), 1, 0, 1);
        chk("rs_pre_stall", stall_hazard, 1);
        cyc(1, jinst(7), 1, 0, 0);
        chk("rs_count", count, 0);
        chk("rs_valid", out_valid, 0);
        chk("rs_stall", stall_hazard, 0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cyc($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 7,
                $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
